// File: rtl/vec_mem_sequencer_if.sv
// Request/micro-op bundle between decode, the vector sequencer and the memory port.
// master = upstream/downstream environment, slave = the sequencer itself.
interface vec_mem_sequencer_if #(
   parameter int MAX_VL = 16,
   parameter int ADDR_W = 16,
   parameter int VLEN_W = 5
);
   localparam int IDX_W = $clog2(MAX_VL);

   logic              in_valid;
   logic              in_ready;
   logic              in_is_store;
   logic [1:0]        in_mode;
   logic [ADDR_W-1:0] in_base;
   logic [ADDR_W-1:0] in_stride;
   logic [4:0]        in_vreg;
   logic [VLEN_W-1:0] in_vlen;
   logic [MAX_VL-1:0] in_mask;
   logic              flush;
   logic              uop_valid;
   logic              uop_ready;
   logic              uop_is_store;
   logic [ADDR_W-1:0] uop_addr;
   logic [IDX_W-1:0]  uop_elem;
   logic [4:0]        uop_vreg;
   logic              uop_last;
   logic              busy;
   logic              done;

   modport master (
      output in_valid, in_is_store, in_mode, in_base, in_stride, in_vreg, in_vlen, in_mask,
      output flush, uop_ready,
      input  in_ready, uop_valid, uop_is_store, uop_addr, uop_elem, uop_vreg, uop_last,
      input  busy, done
   );

   modport slave (
      input  in_valid, in_is_store, in_mode, in_base, in_stride, in_vreg, in_vlen, in_mask,
      input  flush, uop_ready,
      output in_ready, uop_valid, uop_is_store, uop_addr, uop_elem, uop_vreg, uop_last,
      output busy, done
   );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Expands one vector LW/SW request into per-element micro-ops (unit, strided, masked).
// First micro-op 1 cycle after accept, then one per cycle; outputs hold while uop_ready is low.
module vec_mem_sequencer #(
   parameter int MAX_VL = 16,
   parameter int ADDR_W = 16,
   parameter int VLEN_W = 5
) (
   input logic                clk,
   input logic                rst_n,
   vec_mem_sequencer_if.slave sq
);
   localparam int IDX_W = $clog2(MAX_VL);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t            r_state;
   logic [MAX_VL-1:0] r_pend;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_stride;
   logic [ADDR_W-1:0] r_addr;
   logic [IDX_W-1:0]  r_elem;
   logic [4:0]        r_vreg;
   logic              r_is_store;
   logic              r_valid;
   logic              r_last;
   logic              r_done;

   logic [MAX_VL-1:0] w_lmask;
   logic [MAX_VL-1:0] w_eff_mask;
   logic [ADDR_W-1:0] w_in_stride;
   logic [MAX_VL-1:0] w_src_mask;
   logic [ADDR_W-1:0] w_src_base;
   logic [ADDR_W-1:0] w_src_stride;
   logic [IDX_W-1:0]  w_nxt_idx;
   logic [MAX_VL-1:0] w_nxt_pend;
   logic [ADDR_W-1:0] w_nxt_addr;
   logic              w_nxt_last;
   logic              w_accept;
   logic              w_hs;

   function automatic logic [IDX_W-1:0] f_lowest(input logic [MAX_VL-1:0] m);
      f_lowest = '0;
      for (int i = MAX_VL - 1; i >= 0; i--) begin
         if (m[i]) f_lowest = IDX_W'(i);
      end
   endfunction

   // Lengths above MAX_VL saturate naturally: every bit index is below them.
   always_comb begin
      w_lmask = '0;
      for (int i = 0; i < MAX_VL; i++) begin
         w_lmask[i] = (sq.in_vlen > VLEN_W'(i));
      end
   end

   assign w_eff_mask  = (sq.in_mode == 2'd2) ? (sq.in_mask & w_lmask) : w_lmask;
   assign w_in_stride = (sq.in_mode == 2'd1) ? sq.in_stride : ADDR_W'(1);

   // One shared encoder/address path: fed by the incoming request in IDLE, by the pending set in RUN.
   assign w_src_mask   = (r_state == S_IDLE) ? w_eff_mask  : r_pend;
   assign w_src_base   = (r_state == S_IDLE) ? sq.in_base  : r_base;
   assign w_src_stride = (r_state == S_IDLE) ? w_in_stride : r_stride;
   assign w_nxt_idx    = f_lowest(w_src_mask);
   assign w_nxt_pend   = w_src_mask & ~(MAX_VL'(1) << w_nxt_idx);
   assign w_nxt_addr   = w_src_base + ADDR_W'(w_nxt_idx) * w_src_stride;
   assign w_nxt_last   = ~|w_nxt_pend;

   assign w_accept = sq.in_valid && sq.in_ready;
   assign w_hs     = r_valid && sq.uop_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pend     <= '0;
         r_base     <= '0;
         r_stride   <= '0;
         r_addr     <= '0;
         r_elem     <= '0;
         r_vreg     <= '0;
         r_is_store <= 1'b0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_done     <= 1'b0;
      end else if (sq.flush) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (w_accept) begin
                  r_base     <= sq.in_base;
                  r_stride   <= w_in_stride;
                  r_vreg     <= sq.in_vreg;
                  r_is_store <= sq.in_is_store;
                  if (|w_eff_mask) begin
                     r_state <= S_RUN;
                     r_valid <= 1'b1;
                     r_elem  <= w_nxt_idx;
                     r_addr  <= w_nxt_addr;
                     r_last  <= w_nxt_last;
                     r_pend  <= w_nxt_pend;
                  end else begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_hs) begin
                  if (r_last) begin
                     r_state <= S_FIN;
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_elem <= w_nxt_idx;
                     r_addr <= w_nxt_addr;
                     r_last <= w_nxt_last;
                     r_pend <= w_nxt_pend;
                  end
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign sq.in_ready     = (r_state == S_IDLE) && !sq.flush;
   assign sq.uop_valid    = r_valid;
   assign sq.uop_is_store = r_is_store;
   assign sq.uop_addr     = r_addr;
   assign sq.uop_elem     = r_elem;
   assign sq.uop_vreg     = r_vreg;
   assign sq.uop_last     = r_last;
   assign sq.busy         = (r_state != S_IDLE);
   assign sq.done         = r_done;
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Cycle-level bench: each op's expected element/address list is built from the
// addressing rules, then every cycle's outputs are compared against it.
module tb_vec_mem_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vec_mem_sequencer_if #(.MAX_VL(16), .ADDR_W(16), .VLEN_W(5)) sq();

   vec_mem_sequencer #(.MAX_VL(16), .ADDR_W(16), .VLEN_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sq    (sq)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scramble request fields while busy so latching is exercised.
   task automatic garble();
      sq.in_valid    = 1'($urandom_range(0, 1));
      sq.in_is_store = 1'($urandom_range(0, 1));
      sq.in_mode     = 2'($urandom_range(0, 3));
      sq.in_base     = 16'($urandom);
      sq.in_stride   = 16'($urandom);
      sq.in_vreg     = 5'($urandom);
      sq.in_vlen     = 5'($urandom);
      sq.in_mask     = 16'($urandom);
   endtask

   task automatic run_op(input bit st, input bit [1:0] md, input logic [15:0] base,
                         input logic [15:0] stp, input logic [4:0] vreg, input logic [4:0] vlen,
                         input logic [15:0] mask, input int rdy_pct, input int stall_k,
                         input int stall_n, input int flush_k);
      int          ee[$];
      logic [15:0] ea[$];
      int          len;
      int          s;
      int          k;
      int          cyc;
      int          stalled;
      bit          fin;
      bit          r;
      len = (vlen > 16) ? 16 : int'(vlen);
      s   = (md == 2'd1) ? int'(stp) : 1;
      for (int i = 0; i < len; i++) begin
         if (md != 2'd2 || mask[i]) begin
            ee.push_back(i);
            ea.push_back(16'((int'(base) + i * s) % 65536));
         end
      end
      sq.in_valid = 1'b1; sq.in_is_store = st; sq.in_mode = md; sq.in_base = base;
      sq.in_stride = stp; sq.in_vreg = vreg; sq.in_vlen = vlen; sq.in_mask = mask;
      sq.flush = 1'b0; sq.uop_ready = 1'b0;
      #1;
      chk("in_ready_idle", sq.in_ready, 1);
      tick();
      garble();
      k = 0; cyc = 0; stalled = 0; fin = 0;
      while (!fin && cyc < 200) begin
         cyc++;
         if (k < ee.size()) begin
            chk("uop_valid", sq.uop_valid, 1);
            chk("uop_elem", sq.uop_elem, ee[k]);
            chk("uop_addr", sq.uop_addr, ea[k]);
            chk("uop_last", sq.uop_last, (k == ee.size() - 1));
            chk("uop_vreg", sq.uop_vreg, vreg);
            chk("uop_is_store", sq.uop_is_store, st);
            chk("done_mid", sq.done, 0);
            chk("in_ready_busy", sq.in_ready, 0);
            if (k == flush_k) begin
               sq.flush = 1'b1;
               sq.uop_ready = 1'($urandom_range(0, 1));
               tick();
               sq.flush = 1'b0;
               #1;
               chk("flush_valid", sq.uop_valid, 0);
               chk("flush_done", sq.done, 0);
               chk("flush_busy", sq.busy, 0);
               chk("flush_in_ready", sq.in_ready, 1);
               fin = 1;
            end else begin
               if (k == stall_k && stalled < stall_n) begin
                  r = 1'b0;
                  stalled++;
               end else begin
                  r = ($urandom_range(1, 100) <= rdy_pct);
               end
               sq.uop_ready = r;
               tick();
               if (r) k++;
            end
         end else begin
            chk("fin_valid", sq.uop_valid, 0);
            chk("fin_done", sq.done, 1);
            chk("fin_busy", sq.busy, 1);
            chk("fin_in_ready", sq.in_ready, 0);
            tick();
            chk("idle_done", sq.done, 0);
            chk("idle_busy", sq.busy, 0);
            chk("idle_in_ready", sq.in_ready, 1);
            fin = 1;
         end
      end
      if (!fin) chk("op_timeout", 0, 1);
      sq.in_valid = 1'b0;
      sq.uop_ready = 1'b0;
   endtask

   initial begin
      sq.in_valid = 0; sq.in_is_store = 0; sq.in_mode = 0; sq.in_base = 0; sq.in_stride = 0;
      sq.in_vreg = 0; sq.in_vlen = 0; sq.in_mask = 0; sq.flush = 0; sq.uop_ready = 0;
      #12;
      chk("rst_valid", sq.uop_valid, 0);
      chk("rst_in_ready", sq.in_ready, 1);
      #10 rst_n = 1'b1;
      tick();
      chk("init_busy", sq.busy, 0);
      chk("init_done", sq.done, 0);
      chk("init_addr", sq.uop_addr, 0);
      chk("init_elem", sq.uop_elem, 0);
      chk("init_last", sq.uop_last, 0);

      run_op(0, 2'd0, 16'h0010, 16'h0000, 5'd1, 5'd4, 16'h0000, 100, -1, 0, -1);
      run_op(1, 2'd1, 16'h0100, 16'h0003, 5'd2, 5'd3, 16'h0000, 100, 1, 2, -1);
      run_op(0, 2'd2, 16'h0200, 16'h0009, 5'd3, 5'd8, 16'h00A5, 100, -1, 0, -1);
      run_op(1, 2'd2, 16'h0300, 16'h0000, 5'd4, 5'd8, 16'h0000, 100, -1, 0, -1);
      run_op(0, 2'd0, 16'h0400, 16'h0000, 5'd5, 5'd0, 16'hFFFF, 100, -1, 0, -1);
      run_op(1, 2'd0, 16'h0500, 16'h0000, 5'd6, 5'd20, 16'h0000, 100, -1, 0, -1);
      run_op(0, 2'd3, 16'hFFFE, 16'h0007, 5'd7, 5'd4, 16'h0000, 100, -1, 0, -1);
      run_op(0, 2'd0, 16'h0600, 16'h0000, 5'd8, 5'd8, 16'h0000, 100, -1, 0, 2);
      run_op(1, 2'd1, 16'h0700, 16'h0010, 5'd9, 5'd5, 16'h0000, 100, -1, 0, -1);

      // Flush while idle must block an otherwise valid request.
      sq.in_valid = 1'b1; sq.in_mode = 2'd0; sq.in_vlen = 5'd4; sq.flush = 1'b1;
      #1;
      chk("idle_flush_ready", sq.in_ready, 0);
      tick();
      chk("idle_flush_busy", sq.busy, 0);
      chk("idle_flush_valid", sq.uop_valid, 0);
      sq.flush = 1'b0; sq.in_valid = 1'b0;
      tick();

      // Asynchronous reset in the middle of an op.
      sq.in_valid = 1'b1; sq.in_is_store = 1'b1; sq.in_mode = 2'd0; sq.in_base = 16'h0040;
      sq.in_vreg = 5'd11; sq.in_vlen = 5'd8; sq.uop_ready = 1'b1;
      tick();
      sq.in_valid = 1'b0;
      tick();
      chk("pre_rst_valid", sq.uop_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", sq.uop_valid, 0);
      chk("arst_last", sq.uop_last, 0);
      chk("arst_done", sq.done, 0);
      chk("arst_busy", sq.busy, 0);
      chk("arst_addr", sq.uop_addr, 0);
      chk("arst_elem", sq.uop_elem, 0);
      chk("arst_vreg", sq.uop_vreg, 0);
      chk("arst_store", sq.uop_is_store, 0);
      chk("arst_in_ready", sq.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      sq.uop_ready = 1'b0;
      tick();
      run_op(0, 2'd1, 16'h0800, 16'h0002, 5'd12, 5'd6, 16'h0000, 100, -1, 0, -1);

      for (int n = 0; n < 40; n++) begin
         run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                16'($urandom), 5'($urandom), 5'($urandom_range(0, 20)), 16'($urandom),
                $urandom_range(50, 100), $urandom_range(0, 15), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
